// File: rtl/fp_pkg.sv
// Shared constants and types for the 34-bit internal float format
// (2-bit exception, sign, WE-bit exponent, WF-bit fraction).
package fp_pkg;

  localparam int WE   = 8;
  localparam int WF   = 23;
  localparam int W    = WE + WF + 3;
  localparam int MW   = WF + 1;
  localparam int PW   = 2 * MW;
  localparam int BIAS = (1 << (WE - 1)) - 1;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/fp_square_round.sv
// Combinational back end of the squarer: normalise the 48-bit product,
// round to nearest-even, clamp to +inf/+0, pack the result word.
// Ports: prod_i product m*m, exp_i biased operand exponent, res_o result.
module fp_square_round
  import fp_pkg::*;
(
  input  logic [PW-1:0] prod_i,
  input  logic [WE-1:0] exp_i,
  output logic [W-1:0]  res_o
);

  localparam logic signed [WE+1:0] E_BIAS = (WE + 2)'(BIAS);
  localparam logic signed [WE+1:0] E_MAX  = (WE + 2)'((1 << WE) - 1);
  localparam logic signed [WE+1:0] E_ONE  = (WE + 2)'(1);

  logic signed [WE+1:0] e0;
  logic signed [WE+1:0] e1;
  logic signed [WE+1:0] e2;
  logic [WF-1:0] frac;
  logic [WF:0]   sum;
  logic          guard;
  logic          sticky;
  logic          inc;

  always_comb begin
    // 2*E - bias, kept two bits wider so over/underflow stay visible
    e0 = $signed({1'b0, exp_i, 1'b0}) - E_BIAS;
    if (prod_i[PW-1]) begin
      e1     = e0 + E_ONE;
      frac   = prod_i[PW-2 -: WF];
      guard  = prod_i[PW-2-WF];
      sticky = |prod_i[PW-3-WF:0];
    end else begin
      e1     = e0;
      frac   = prod_i[PW-3 -: WF];
      guard  = prod_i[PW-3-WF];
      sticky = |prod_i[PW-4-WF:0];
    end
    inc = guard & (frac[0] | sticky);
    sum = {1'b0, frac} + {{WF{1'b0}}, inc};
    // carry out means mantissa rolled to 2.0: fraction is already 0
    e2  = sum[WF] ? e1 + E_ONE : e1;
    if (e2 >= E_MAX) begin
      res_o = {EXC_INF, {(W - 2){1'b0}}};
    end else if (e2 <= 0) begin
      res_o = {EXC_ZERO, {(W - 2){1'b0}}};
    end else begin
      res_o = {EXC_NORMAL, 1'b0, e2[WE-1:0], sum[WF-1:0]};
    end
  end

endmodule

// File: rtl/fp_square_seq.sv
// Sequential squarer R = X*X with a radix-2 shift-add mantissa multiplier.
// Ports: clk, rst_n, X/in_valid/in_ready in, R/out_valid/out_ready out.
module fp_square_seq
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] X,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] R,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e        state_q;
  logic [4:0]    cnt_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] mcand_q;
  logic [MW-1:0] mplier_q;
  logic [WE-1:0] exp_q;
  logic [W-1:0]  r_q;
  logic          ov_q;

  logic [PW-1:0] acc_d;
  logic [W-1:0]  rnd_res;
  logic          unused_sign;

  // squaring never depends on the operand sign
  assign unused_sign = X[W-3];

  assign in_ready  = (state_q == S_IDLE);
  assign R         = r_q;
  assign out_valid = ov_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  fp_square_round u_round (
    .prod_i (acc_q),
    .exp_i  (exp_q),
    .res_o  (rnd_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      exp_q    <= '0;
      r_q      <= '0;
      ov_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (X[W-1 -: 2] == EXC_NORMAL) begin
              mcand_q  <= {{MW{1'b0}}, 1'b1, X[WF-1:0]};
              mplier_q <= {1'b1, X[WF-1:0]};
              exp_q    <= X[WF +: WE];
              acc_q    <= '0;
              cnt_q    <= 5'(MW - 1);
              state_q  <= S_MUL;
            end else begin
              // zero, inf, NaN: code only, sign and fields cleared
              r_q     <= {X[W-1 -: 2], {(W - 2){1'b0}}};
              ov_q    <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            state_q <= S_NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_NORM: begin
          r_q     <= rnd_res;
          ov_q    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square_seq.sv
// Randomised self-checking bench for fp_square_seq against an
// arithmetic reference model of the squaring and rounding rules.
module tb_fp_square_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] X;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] R;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  fp_square_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [33:0] got,
                       input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ref_sq(input logic [33:0] x);
    longint unsigned m, p, q, rem, half;
    int e, s;
    logic [33:0] r;
    case (x[33:32])
      2'b00: r = 34'h0_0000_0000;
      2'b10: r = 34'h2_0000_0000;
      2'b11: r = 34'h3_0000_0000;
      default: begin
        m = 64'h80_0000 + 64'(x[22:0]);
        p = m * m;
        e = 2 * int'(x[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
          e++;
          s = 24;
        end else begin
          s = 23;
        end
        q    = p >> s;
        rem  = p - (q << s);
        half = 64'd1 << (s - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e++;
        end
        if (e >= 255)    r = 34'h2_0000_0000;
        else if (e <= 0) r = 34'h0_0000_0000;
        else r = {2'b01, 1'b0, 8'(e), q[22:0]};
      end
    endcase
    return r;
  endfunction

  task automatic send(input logic [33:0] x);
    check("accept_rdy", {33'b0, in_ready}, 34'd1);
    X = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic hold(input int n, input logic [33:0] exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("hold_r", R, exp);
      check("hold_busy", {33'b0, in_ready}, 34'd0);
      check("hold_ov", {33'b0, out_valid}, 34'd1);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ov_drop", {33'b0, out_valid}, 34'd0);
    check("rdy_back", {33'b0, in_ready}, 34'd1);
  endtask

  task automatic run_one(input string tag, input logic [33:0] x,
                         input int nhold);
    int lat;
    logic [33:0] exp;
    exp = ref_sq(x);
    send(x);
    wait_out(lat);
    if (x[33:32] == 2'b01) begin
      check({tag, "_lat"}, 34'(lat), 34'd25);
    end else begin
      check({tag, "_lat"}, {33'b0, lat <= 1}, 34'd1);
    end
    check(tag, R, exp);
    check({tag, "_sign"}, {33'b0, R[31]}, 34'd0);
    hold(nhold, exp);
    take();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [33:0] x;
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    X = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r", R, 34'h0);
    check("rst_ov", {33'b0, out_valid}, 34'd0);
    check("rst_rdy", {33'b0, in_ready}, 34'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one("sq3", 34'h1_4040_0000, 0);
    check("sq3_model", ref_sq(34'h1_4040_0000), 34'h1_4110_0000);
    run_one("sqm2", 34'h1_C000_0000, 1);
    run_one("sq1ulp", 34'h1_3F80_0001, 0);
    run_one("ovf", 34'h1_6000_0000, 0);
    run_one("unf", 34'h1_1800_0000, 0);
    run_one("nan", 34'h3_8000_0000, 0);
    run_one("ninf", 34'h2_8000_0000, 0);
    run_one("zero", 34'h0_8000_0000, 2);

    // backpressure with a competing input held high
    send(34'h1_4040_0000);
    wait_out(lat);
    check("bp_lat", 34'(lat), 34'd25);
    X = 34'h1_C000_0000;
    in_valid = 1'b1;
    hold(10, 34'h1_4110_0000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drop", {33'b0, out_valid}, 34'd0);
    check("bp_idle", {33'b0, in_ready}, 34'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_taken", {33'b0, in_ready}, 34'd0);
    wait_out(lat);
    check("bp2_lat", 34'(lat), 34'd25);
    check("bp2_r", R, 34'h1_4080_0000);
    take();

    // abort in the middle of the multiply
    send(34'h1_4040_0000);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ov", {33'b0, out_valid}, 34'd0);
    check("abort_r", R, 34'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_rdy", {33'b0, in_ready}, 34'd1);
    repeat (30) begin
      @(posedge clk);
      #1;
      check("abort_quiet", {33'b0, out_valid}, 34'd0);
    end
    run_one("after_rst", 34'h1_4040_0000, 0);

    for (int i = 0; i < 60; i++) begin
      x[31:0] = $urandom;
      x[33:32] = ($urandom_range(0, 9) < 8) ? 2'b01
                                            : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        x[30:23] = 8'($urandom_range(100, 160));
      run_one("rand", x, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
